standby_mode_sequencer: RTL and testbench

Sequences run-time switching of the standby target between the I2C and I3C standby controllers. It accepts a requested mode from CSR configuration and commits it only when the bus is provably idle and no TTI write is in flight. It drives the select that steers the shared TTI queues and bus-event outputs, and the per-controller enables. It sits between the configuration registers and the I2C/I3C standby controller pair.

---
 rtl/standby_mode_sequencer_if.sv | 34 +++
 rtl/standby_mode_sequencer.sv | 134 +++++++++++++
 tb/tb_standby_mode_sequencer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/standby_mode_sequencer_if.sv
// Signal bundle between the CSR/controller side and the standby mode sequencer.
// The sequencer uses the slave modport; whoever drives the requests uses master.
interface standby_mode_sequencer_if;
    logic        enable_i;
    logic        mode_req_i;
    logic        scl_i;
    logic        sda_i;
    logic        bus_start_i;
    logic        bus_stop_i;
    logic        rx_inflight_i;
    logic [19:0] t_bus_free_i;

    logic        sel_i3c_o;
    logic        i2c_en_o;
    logic        i3c_en_o;
    logic        tti_gate_o;
    logic        switch_busy_o;
    logic        switch_done_o;
    logic        timeout_o;

    modport master (
        output enable_i, mode_req_i, scl_i, sda_i, bus_start_i, bus_stop_i,
               rx_inflight_i, t_bus_free_i,
        input  sel_i3c_o, i2c_en_o, i3c_en_o, tti_gate_o, switch_busy_o,
               switch_done_o, timeout_o
    );

    modport slave (
        input  enable_i, mode_req_i, scl_i, sda_i, bus_start_i, bus_stop_i,
               rx_inflight_i, t_bus_free_i,
        output sel_i3c_o, i2c_en_o, i3c_en_o, tti_gate_o, switch_busy_o,
               switch_done_o, timeout_o
    );
endinterface

// File: rtl/standby_mode_sequencer.sv
// Commits I2C/I3C standby mode changes only once the bus is idle and TTI writes have drained.
// Define I3C_STANDBY_SWITCH_TIMEOUT_EN to force a switch after TimeoutCycles stuck in WAIT_IDLE.
module standby_mode_sequencer #(
    parameter logic [19:0] TimeoutCycles = 20'hFFFFF
) (
    input logic                     clk_i,
    input logic                     rst_ni,
    standby_mode_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        RUN,
        WAIT_IDLE,
        WAIT_FREE,
        DRAIN,
        SWAP
    } state_t;

    state_t      state_q, state_d;
    logic [19:0] free_cnt_q, free_cnt_d;
    logic        in_xfer_q;
    logic        sel_q, sel_d;
    logic        i2c_en_q, i3c_en_q, gate_q, busy_q, done_q;
    logic        req_match, bus_idle, line_busy, en_allowed;
    logic        timeout_hit, forced_entry;

    assign req_match    = (bus.mode_req_i == sel_q);
    assign bus_idle     = ~in_xfer_q & bus.scl_i & bus.sda_i;
    assign line_busy    = ~bus.scl_i | ~bus.sda_i | bus.bus_start_i;
    assign forced_entry = (state_q == WAIT_IDLE) & ~req_match & timeout_hit;

    // Cancellation wins over every other exit; a forced timeout wins over waiting for idle.
    always_comb begin
        state_d    = state_q;
        free_cnt_d = '0;
        unique case (state_q)
            RUN: begin
                if (!req_match) state_d = WAIT_IDLE;
            end
            WAIT_IDLE: begin
                if (req_match)        state_d = RUN;
                else if (timeout_hit) state_d = DRAIN;
                else if (bus_idle)    state_d = WAIT_FREE;
            end
            WAIT_FREE: begin
                if (req_match)                              state_d = RUN;
                else if (line_busy)                         state_d = WAIT_IDLE;
                else if (free_cnt_q >= bus.t_bus_free_i)    state_d = DRAIN;
                else if (free_cnt_q != 20'hFFFFF)           free_cnt_d = free_cnt_q + 20'd1;
                else                                        free_cnt_d = free_cnt_q;
            end
            DRAIN: begin
                if (!bus.rx_inflight_i) state_d = SWAP;
            end
            SWAP: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    assign sel_d      = (state_q == SWAP) ? ~sel_q : sel_q;
    assign en_allowed = bus.enable_i & ((state_d == RUN) | (state_d == WAIT_IDLE) |
                                        (state_d == WAIT_FREE));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= RUN;
            free_cnt_q <= '0;
            in_xfer_q  <= 1'b0;
            sel_q      <= 1'b0;
            i2c_en_q   <= 1'b0;
            i3c_en_q   <= 1'b0;
            gate_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            free_cnt_q <= free_cnt_d;
            in_xfer_q  <= bus.bus_start_i | (in_xfer_q & ~bus.bus_stop_i);
            sel_q      <= sel_d;
            i2c_en_q   <= en_allowed & ~sel_d;
            i3c_en_q   <= en_allowed & sel_d;
            gate_q     <= (state_d == DRAIN) | (state_d == SWAP);
            busy_q     <= (state_d != RUN);
            done_q     <= (state_d == SWAP);
        end
    end

`ifdef I3C_STANDBY_SWITCH_TIMEOUT_EN
    logic [19:0] wait_cnt_q;
    logic        forced_q, timeout_q;

    assign timeout_hit = (wait_cnt_q == TimeoutCycles);

    // The sticky flag survives the forced commit and clears on the next ordinary one.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_cnt_q <= '0;
            forced_q   <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            wait_cnt_q <= ((state_q == WAIT_IDLE) && (state_d == WAIT_IDLE)) ?
                          wait_cnt_q + 20'd1 : 20'd0;
            if (forced_entry) begin
                forced_q  <= 1'b1;
                timeout_q <= 1'b1;
            end else if (state_q == SWAP) begin
                forced_q <= 1'b0;
                if (!forced_q) timeout_q <= 1'b0;
            end
        end
    end

    assign bus.timeout_o = timeout_q;
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign unused_timeout = ^{TimeoutCycles, forced_entry};
    assign bus.timeout_o  = 1'b0;
`endif

    assign bus.sel_i3c_o     = sel_q;
    assign bus.i2c_en_o      = i2c_en_q;
    assign bus.i3c_en_o      = i3c_en_q;
    assign bus.tti_gate_o    = gate_q;
    assign bus.switch_busy_o = busy_q;
    assign bus.switch_done_o = done_q;

endmodule

// File: tb/tb_standby_mode_sequencer.sv
// Directed-random bench for standby_mode_sequencer; expected outputs come from switch timeline arithmetic.
// Output vector order: {sel, i2c_en, i3c_en, tti_gate, busy, done, timeout}.
module tb_standby_mode_sequencer;

    localparam logic [19:0] TIMEOUT = 20'd100;

    logic clk_i = 1'b0;
    logic rst_ni;
    int   vectors = 0;
    int   miscompares = 0;
    bit   model_sel = 1'b0;

    standby_mode_sequencer_if bus ();

    standby_mode_sequencer #(.TimeoutCycles(TIMEOUT)) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [6:0] expected);
        logic [6:0] observed;
        observed = {bus.sel_i3c_o, bus.i2c_en_o, bus.i3c_en_o, bus.tti_gate_o,
                    bus.switch_busy_o, bus.switch_done_o, bus.timeout_o};
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // One mode request from RUN. Step i is the i-th rising edge after the request is driven.
    // The idle check passes at edge 'entry', the bus-free count needs n+1 edges, then DRAIN.
    task automatic applyStimulus(input string tag, input bit en, input int n,
                                 input int stop_at, input int sda_drop,
                                 input int inflight_until, input int revert_at,
                                 input bit sticky);
        bit         target, cur_sel, gate, busy, done, tout;
        int         entry, drain_at, done_at, last;
        logic [6:0] exp_v;
        target = ~model_sel;
        entry = 2;
        if (stop_at > 0) entry = stop_at + 1;
        if (sda_drop > 0) entry = sda_drop + 1;
        drain_at = entry + n + 1;
        done_at = (inflight_until > drain_at) ? inflight_until + 1 : drain_at + 1;
        last = (revert_at > 0) ? revert_at + 3 : done_at + 2;
        bus.enable_i = en;
        bus.t_bus_free_i = 20'(n);
        bus.mode_req_i = target;
        for (int i = 1; i <= last; i++) begin
            bus.bus_stop_i = (i == stop_at);
            bus.sda_i = (i != sda_drop);
            bus.rx_inflight_i = (i <= inflight_until);
            if (revert_at > 0 && i == revert_at) bus.mode_req_i = model_sel;
            tick();
            if (revert_at > 0) begin
                cur_sel = model_sel;
                gate = 1'b0;
                busy = (i < revert_at);
                done = 1'b0;
                tout = sticky;
            end else begin
                cur_sel = (i > done_at) ? target : model_sel;
                gate = (i >= drain_at) && (i <= done_at);
                busy = (i <= done_at);
                done = (i == done_at);
                tout = sticky && (i <= done_at);
            end
            exp_v = {cur_sel, ~gate & en & ~cur_sel, ~gate & en & cur_sel, gate, busy, done, tout};
            checkOutput($sformatf("%s@%0d", tag, i), exp_v);
        end
        if (revert_at == 0) model_sel = target;
        bus.bus_stop_i = 1'b0;
        bus.sda_i = 1'b1;
        bus.rx_inflight_i = 1'b0;
    endtask

    task automatic pulseStart(input bit with_stop);
        bus.bus_start_i = 1'b1;
        bus.bus_stop_i = with_stop;
        tick();
        bus.bus_start_i = 1'b0;
        bus.bus_stop_i = 1'b0;
    endtask

    initial begin
        int n, k, h;
        rst_ni = 1'b0;
        bus.enable_i = 1'b1;
        bus.mode_req_i = 1'b0;
        bus.scl_i = 1'b1;
        bus.sda_i = 1'b1;
        bus.bus_start_i = 1'b0;
        bus.bus_stop_i = 1'b0;
        bus.rx_inflight_i = 1'b0;
        bus.t_bus_free_i = 20'd10;
        tick();
        tick();
        checkOutput("in_reset", 7'b0000000);
        rst_ni = 1'b1;
        tick();
        checkOutput("after_reset", 7'b0100000);
        tick();
        checkOutput("run_steady", 7'b0100000);

        $display("[TB] basic switch to I3C, t_bus_free=10");
        applyStimulus("basic_i3c", 1'b1, 10, 0, 0, 0, 0, 1'b0);

        n = $urandom_range(0, 15);
        $display("[TB] switch back to I2C with enable low, n=%0d", n);
        applyStimulus("en_low_i2c", 1'b0, n, 0, 0, 0, 0, 1'b0);

        n = $urandom_range(1, 15);
        k = $urandom_range(20, 60);
        $display("[TB] transfer in progress, stop at %0d, n=%0d", k, n);
        pulseStart($urandom_range(0, 1) == 1);
        applyStimulus("xfer_wait", 1'b1, n, k, 0, 0, 0, 1'b0);

        $display("[TB] SDA glitch at count 7 of 10");
        applyStimulus("sda_glitch", 1'b1, 10, 0, 3 + 7, 0, 0, 1'b0);

        n = $urandom_range(3, 15);
        k = $urandom_range(3, n + 3);
        $display("[TB] SDA glitch at edge %0d, n=%0d", k, n);
        applyStimulus("sda_rand", 1'b1, n, 0, k, 0, 0, 1'b0);

        n = $urandom_range(0, 12);
        $display("[TB] rx in flight for 5 DRAIN cycles, n=%0d", n);
        applyStimulus("drain_hold", 1'b1, n, 0, 0, n + 3 + 5, 0, 1'b0);

        n = $urandom_range(2, 15);
        k = $urandom_range(2, n + 3);
        $display("[TB] request reverted at edge %0d, n=%0d", k, n);
        applyStimulus("revert", 1'b1, n, 0, 0, 0, k, 1'b0);

        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(0, 15);
            k = ($urandom_range(0, 1) == 1) ? $urandom_range(3, n + 3) : 0;
            h = $urandom_range(0, n + 14);
            applyStimulus($sformatf("rand%0d", r), $urandom_range(0, 3) != 0, n, 0, k, h, 0, 1'b0);
        end

`ifdef I3C_STANDBY_SWITCH_TIMEOUT_EN
        $display("[TB] bus stuck mid-transfer, forced switch after %0d", TIMEOUT);
        bus.enable_i = 1'b1;
        pulseStart(1'b0);
        bus.mode_req_i = ~model_sel;
        for (int i = 1; i <= int'(TIMEOUT) + 5; i++) begin
            bit cs, g;
            tick();
            cs = (i > int'(TIMEOUT) + 3) ? ~model_sel : model_sel;
            g = (i >= int'(TIMEOUT) + 2) && (i <= int'(TIMEOUT) + 3);
            checkOutput($sformatf("forced@%0d", i),
                        {cs, ~g & ~cs, ~g & cs, g, i <= int'(TIMEOUT) + 3,
                         i == int'(TIMEOUT) + 3, i >= int'(TIMEOUT) + 2});
        end
        model_sel = ~model_sel;
        applyStimulus("after_forced", 1'b1, 4, 5, 0, 0, 0, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
